display_timing: RTL

// Video raster timing generator feeding the per-channel dvi_encoder stages.
// - Walks a pixel counter (hcnt) and a line counter (vcnt) over one frame.
// - Produces registered active, hsync/vsync, ctrl[1:0] and pixel position.
// - active drives the encoders' active input; ctrl drives the blue-channel

---
 rtl/display_timing.sv | 137 +++++++++++++
 1 files changed

// File: rtl/display_timing.sv
// display_timing: raster timing generator for the dvi_encoder stages.
// A pixel counter (hcnt) and a line counter (vcnt) walk one frame. Each enabled
// cycle registers the decode of the current position, then the counters advance.
// Optional feature macro: DISPLAY_TIMING_PREFETCH_EN adds fetch/fetch_x/fetch_y,
// which show the position that will be presented on the next enabled cycle.
module display_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  ctrl,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        new_line,
  output logic        new_frame
`ifdef DISPLAY_TIMING_PREFETCH_EN
  ,
  output logic        fetch,
  output logic [11:0] fetch_x,
  output logic [11:0] fetch_y
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters are 12 bits wide, so neither total may exceed 4096.
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_too_big
    $error("display_timing: H_TOTAL and V_TOTAL must both be <= 4096");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_phase_too_small
    $error("display_timing: every timing phase must be at least 1");
  end

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  // Phase boundaries are 13 bits so an H_ACTIVE of up to 4096 still compares correctly.
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END  = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_BEG = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END = 13'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic below(input logic [11:0] cnt, input logic [12:0] lim);
    return {1'b0, cnt} < lim;
  endfunction

  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [11:0] hcnt_nxt;
  logic [11:0] vcnt_nxt;
  logic        cur_active;
  logic        cur_hsync;
  logic        cur_vsync;

  // Next-position arithmetic and decode of the current position.
  always_comb begin
    hcnt_nxt = hcnt + 12'd1;
    vcnt_nxt = vcnt;
    if (hcnt == H_LAST) begin
      hcnt_nxt = '0;
      vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 12'd1;
    end
    cur_active = below(hcnt, H_ACT_END) && below(vcnt, V_ACT_END);
    cur_hsync  = (!below(hcnt, H_SYNC_BEG) && below(hcnt, H_SYNC_END)) ? HS_POL : ~HS_POL;
    cur_vsync  = (!below(vcnt, V_SYNC_BEG) && below(vcnt, V_SYNC_END)) ? VS_POL : ~VS_POL;
  end

  // Position counters and registered timing outputs; pulses clear on stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      x         <= '0;
      y         <= '0;
      active    <= 1'b0;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      new_line  <= 1'b0;
      new_frame <= 1'b0;
    end else begin
      new_line  <= 1'b0;
      new_frame <= 1'b0;
      if (enable) begin
        x         <= hcnt;
        y         <= vcnt;
        active    <= cur_active;
        hsync     <= cur_hsync;
        vsync     <= cur_vsync;
        new_line  <= (hcnt == 12'd0);
        new_frame <= (hcnt == 12'd0) && (vcnt == 12'd0);
        hcnt      <= hcnt_nxt;
        vcnt      <= vcnt_nxt;
      end
    end
  end

  assign ctrl = {vsync, hsync};

`ifdef DISPLAY_TIMING_PREFETCH_EN
  logic nxt_active;

  // Visibility of the position the counters move to this cycle.
  always_comb begin
    nxt_active = below(hcnt_nxt, H_ACT_END) && below(vcnt_nxt, V_ACT_END);
  end

  // One-cycle lookahead for the pixel source, held on stalls like x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch   <= 1'b0;
      fetch_x <= '0;
      fetch_y <= '0;
    end else if (enable) begin
      fetch   <= nxt_active;
      fetch_x <= hcnt_nxt;
      fetch_y <= vcnt_nxt;
    end
  end
`endif

endmodule
